flash_read_ctrl: RTL and testbench

- SPI flash read master, mode 0, using the standard Read Data command (0x03) with a 24-bit address.
- A single-cycle key_flag starts one read of DATA_NUM bytes from RD_ADDR.
- Each received byte is presented on rd_data with a one-cycle rd_valid strobe, for a downstream FIFO or UART TX.
- It is the read-side counterpart of the page-program controller and drives the same cs_n/sck/mosi pins, plus miso.

---
 rtl/flash_read_ctrl_if.sv | 11 +
 rtl/flash_read_ctrl.sv | 165 ++++++++++++++++
 tb/tb_flash_read_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_read_ctrl_if.sv
// SPI pin bundle between the flash read master and the serial flash.
// The master drives chip select, clock and data in; the flash drives miso.
interface flash_read_ctrl_if;
   logic cs_n;
   logic sck;
   logic mosi;
   logic miso;

   modport master (output cs_n, output sck, output mosi, input miso);
   modport slave  (input cs_n, input sck, input mosi, output miso);
endinterface

// File: rtl/flash_read_ctrl.sv
// SPI flash read master, mode 0: sends Read Data (RD_CMD) plus a 24-bit address,
// then streams DATA_NUM bytes out on rd_data/rd_valid. One 32-clock slot per byte.
//
// state | meaning
// IDLE  | cs_n high, counters cleared, waiting for key_flag
// SETUP | one slot with cs_n low and sck idle (chip-select setup margin)
// SEND  | slots 1..4: command, address[23:16], address[15:8], address[7:0]
// RECV  | slots 5..DATA_NUM+4: one byte shifted in per slot
// HOLD  | one slot with sck low, then cs_n released and done pulsed
module flash_read_ctrl #(
   parameter logic [15:0] DATA_NUM = 16'd270,
   parameter logic [7:0]  RD_CMD   = 8'h03,
   parameter logic [23:0] RD_ADDR  = 24'h0000C8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              key_flag,
   flash_read_ctrl_if.master spi,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      SETUP = 5'b00010,
      SEND  = 5'b00100,
      RECV  = 5'b01000,
      HOLD  = 5'b10000
   } state_t;

   // Slot counter carries one extra bit so DATA_NUM+4 fits when DATA_NUM=65535.
   localparam logic [16:0] LAST_SEND = 17'd4;
   localparam logic [16:0] LAST_RECV = {1'b0, DATA_NUM} + 17'd4;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  cnt_clk;
   logic [16:0] cnt_byte;
   logic [1:0]  cnt_sck;
   logic [2:0]  cnt_bit;
   logic [7:0]  shift_reg;
   logic [7:0]  tx_byte;
   logic        cs_n_r;
   logic        sck_r;
   logic        mosi_r;
   logic        slot_end;
   logic        shifting;

   assign slot_end = (cnt_clk == 5'd31);
   assign shifting = (state == SEND) || (state == RECV);

   assign spi.cs_n = cs_n_r;
   assign spi.sck  = sck_r;
   assign spi.mosi = mosi_r;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (key_flag) state_nxt = SETUP;
         end
         SETUP: begin
            if (slot_end) state_nxt = SEND;
         end
         SEND: begin
            if (slot_end && (cnt_byte == LAST_SEND)) state_nxt = RECV;
         end
         RECV: begin
            if (slot_end && (cnt_byte == LAST_RECV)) state_nxt = HOLD;
         end
         HOLD: begin
            if (slot_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      case (cnt_byte)
         17'd1:   tx_byte = RD_CMD;
         17'd2:   tx_byte = RD_ADDR[23:16];
         17'd3:   tx_byte = RD_ADDR[15:8];
         17'd4:   tx_byte = RD_ADDR[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_clk   <= 5'd0;
         cnt_byte  <= 17'd0;
         cnt_sck   <= 2'd0;
         cnt_bit   <= 3'd0;
         shift_reg <= 8'h00;
         cs_n_r    <= 1'b1;
         sck_r     <= 1'b0;
         mosi_r    <= 1'b0;
         rd_data   <= 8'h00;
         rd_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;

         if (state == IDLE) begin
            cnt_clk  <= 5'd0;
            cnt_byte <= 17'd0;
            if (key_flag) begin
               cs_n_r <= 1'b0;
               busy   <= 1'b1;
            end
         end else begin
            cnt_clk <= cnt_clk + 5'd1;
            if (slot_end) cnt_byte <= cnt_byte + 17'd1;
         end

         // SPI clock and bit counters only run while bits are on the wire.
         if (shifting) begin
            cnt_sck <= cnt_sck + 2'd1;
            if (cnt_sck == 2'd3) cnt_bit <= cnt_bit + 3'd1;
            if (cnt_sck == 2'd0) sck_r <= 1'b0;
            else if (cnt_sck == 2'd2) sck_r <= 1'b1;
         end else begin
            cnt_sck <= 2'd0;
            cnt_bit <= 3'd0;
            sck_r   <= 1'b0;
         end

         if (state == SEND) begin
            if (cnt_sck == 2'd0) mosi_r <= tx_byte[3'd7 - cnt_bit];
         end else begin
            mosi_r <= 1'b0;
         end

         // miso is sampled one clock after sck rises; the last bit goes straight to rd_data.
         if ((state == RECV) && (cnt_sck == 2'd3)) begin
            shift_reg <= {shift_reg[6:0], spi.miso};
            if (slot_end) begin
               rd_data  <= {shift_reg[6:0], spi.miso};
               rd_valid <= 1'b1;
            end
         end

         if ((state == HOLD) && slot_end) begin
            cs_n_r   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            cnt_byte <= 17'd0;
         end
      end
   end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: three instances (DATA_NUM 4, 270, 1) share one
// behavioural flash that decodes the command/address and serves bytes from mem.
module tb_flash_read_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [2:0] key_flag = 3'b000;
   int         sel = 0;
   logic       rnd_mode = 1'b0;
   logic       rnd_bit = 1'b0;
   logic       flash_bit = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [0:1023];
   logic [7:0] exp_q [$];
   logic [7:0] obs_q [$];

   logic [7:0] rd_data0, rd_data1, rd_data2;
   logic [2:0] rd_valid_v, busy_v, done_v;

   flash_read_ctrl_if spi0 ();
   flash_read_ctrl_if spi1 ();
   flash_read_ctrl_if spi2 ();

   always #10 sys_clk = ~sys_clk;

   flash_read_ctrl #(.DATA_NUM(16'd4)) dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_flag(key_flag[0]), .spi(spi0),
      .rd_data(rd_data0), .rd_valid(rd_valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   flash_read_ctrl #(.DATA_NUM(16'd270)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_flag(key_flag[1]), .spi(spi1),
      .rd_data(rd_data1), .rd_valid(rd_valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   flash_read_ctrl #(.DATA_NUM(16'd1)) dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_flag(key_flag[2]), .spi(spi2),
      .rd_data(rd_data2), .rd_valid(rd_valid_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   assign spi0.miso = rnd_mode ? rnd_bit : ((sel == 0) ? flash_bit : 1'b0);
   assign spi1.miso = rnd_mode ? rnd_bit : ((sel == 1) ? flash_bit : 1'b0);
   assign spi2.miso = rnd_mode ? rnd_bit : ((sel == 2) ? flash_bit : 1'b0);

   logic       m_cs_n, m_sck, m_mosi, m_rd_valid, m_busy, m_done;
   logic [7:0] m_rd_data;

   always_comb begin
      m_cs_n = spi0.cs_n; m_sck = spi0.sck; m_mosi = spi0.mosi;
      m_rd_valid = rd_valid_v[0]; m_busy = busy_v[0]; m_done = done_v[0]; m_rd_data = rd_data0;
      if (sel == 1) begin
         m_cs_n = spi1.cs_n; m_sck = spi1.sck; m_mosi = spi1.mosi;
         m_rd_valid = rd_valid_v[1]; m_busy = busy_v[1]; m_done = done_v[1]; m_rd_data = rd_data1;
      end else if (sel == 2) begin
         m_cs_n = spi2.cs_n; m_sck = spi2.sck; m_mosi = spi2.mosi;
         m_rd_valid = rd_valid_v[2]; m_busy = busy_v[2]; m_done = done_v[2]; m_rd_data = rd_data2;
      end
   end

   // Flash model: shifts in 32 command/address bits on sck rise, drives data on sck fall.
   int          rise_cnt = 0;
   int          fall_cnt = 0;
   int          last_rises = 0;
   int          mosi_bad = 0;
   logic [31:0] rx_sr = 32'h0;
   logic        prev_sck = 1'b0;
   logic        prev_cs = 1'b1;

   always @(m_sck, m_cs_n) begin
      int          idx;
      logic [23:0] a;
      logic [7:0]  b;
      if (m_cs_n === 1'b1) begin
         if (prev_cs === 1'b0) last_rises = rise_cnt;
         rise_cnt = 0;
         fall_cnt = 0;
      end else if (m_cs_n === 1'b0) begin
         if (prev_cs === 1'b1) begin
            rx_sr    = 32'h0;
            mosi_bad = 0;
         end
         if (m_sck === 1'b1 && prev_sck === 1'b0) begin
            if (rise_cnt < 32) rx_sr = {rx_sr[30:0], m_mosi};
            else if (m_mosi !== 1'b0) mosi_bad++;
            rise_cnt++;
         end else if (m_sck === 1'b0 && prev_sck === 1'b1) begin
            fall_cnt++;
            if (fall_cnt >= 32) begin
               idx = fall_cnt - 32;
               a = rx_sr[23:0] + 24'(idx / 8);
               b = mem[a[9:0]];
               flash_bit = b[7 - (idx % 8)];
            end
         end
      end
      prev_sck = m_sck;
      prev_cs  = m_cs_n;
   end

   int cs_low_cnt, cs_fall_cnt, done_cnt, valid_cnt, first_valid_off, gap_bad, busy_bad;

   // Starts one read on instance s and records what the selected instance does
   // until one cycle after done; x1/x2 are extra key_flag cycles (-1 = none).
   task automatic run_txn(input int s, input int x1, input int x2);
      int   cyc, last_valid, done_cyc;
      logic last_cs;
      cs_low_cnt = 0; cs_fall_cnt = 0; done_cnt = 0; valid_cnt = 0;
      first_valid_off = -1; gap_bad = 0; busy_bad = 0;
      obs_q.delete();
      cyc = 0; last_valid = 0; done_cyc = 0; last_cs = 1'b1;
      @(negedge sys_clk);
      key_flag[s] = 1'b1;
      while (cyc < 10000) begin
         @(negedge sys_clk);
         key_flag[s] = (cyc == x1) || (cyc == x2);
         if (m_cs_n === 1'b0) cs_low_cnt++;
         if (last_cs === 1'b1 && m_cs_n === 1'b0) cs_fall_cnt++;
         last_cs = m_cs_n;
         if (m_busy !== ~m_cs_n) busy_bad++;
         if (m_rd_valid === 1'b1) begin
            if (valid_cnt == 0) first_valid_off = cyc;
            else if (cyc - last_valid != 32) gap_bad++;
            last_valid = cyc;
            valid_cnt++;
            obs_q.push_back(m_rd_data);
         end
         if (m_done === 1'b1) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
         end
         if (done_cnt > 0 && cyc >= done_cyc + 1) break;
         cyc++;
      end
      key_flag[s] = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst  = 1'b1;
      rnd_mode = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         rnd_bit = 1'($urandom_range(0, 1));
         checks++;
         if ({spi2.cs_n, spi1.cs_n, spi0.cs_n} !== 3'b111) begin
            errors++; $display("FAIL reset_cs_n: got %b want 111", {spi2.cs_n, spi1.cs_n, spi0.cs_n});
         end
         checks++;
         if ({spi2.sck, spi1.sck, spi0.sck, spi2.mosi, spi1.mosi, spi0.mosi} !== 6'b0) begin
            errors++; $display("FAIL reset_sck_mosi: got %b want 000000",
                               {spi2.sck, spi1.sck, spi0.sck, spi2.mosi, spi1.mosi, spi0.mosi});
         end
         checks++;
         if ({rd_valid_v, busy_v, done_v} !== 9'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000000", {rd_valid_v, busy_v, done_v});
         end
         checks++;
         if ({rd_data2, rd_data1, rd_data0} !== 24'h0) begin
            errors++; $display("FAIL reset_rd_data: got %h want 000000", {rd_data2, rd_data1, rd_data0});
         end
      end
      sys_rst  = 1'b0;
      rnd_mode = 1'b0;
   endtask

   task automatic test_cmd_addr();
      sel = 0;
      run_txn(0, -1, -1);
      checks++;
      if (rx_sr[31:24] !== 8'h03) begin
         errors++; $display("FAIL cmd_opcode: got %h want 03", rx_sr[31:24]);
      end
      checks++;
      if (rx_sr[23:0] !== 24'h0000C8) begin
         errors++; $display("FAIL cmd_address: got %h want 0000c8", rx_sr[23:0]);
      end
      checks++;
      if (cs_low_cnt != 320 || cs_fall_cnt != 1) begin
         errors++; $display("FAIL cmd_cs_low: got %0d cycles/%0d falls want 320/1", cs_low_cnt, cs_fall_cnt);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++; $display("FAIL cmd_done: got %0d pulses want 1", done_cnt);
      end
      checks++;
      if (last_rises != 64 || mosi_bad != 0) begin
         errors++; $display("FAIL cmd_sck_mosi: got %0d rises/%0d bad mosi want 64/0", last_rises, mosi_bad);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++; $display("FAIL cmd_busy: got %0d mismatching cycles want 0", busy_bad);
      end
   endtask

   task automatic test_read_data();
      logic [7:0] got, want;
      sel = 0;
      exp_q.delete();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      run_txn(0, -1, -1);
      checks++;
      if (valid_cnt != 4) begin
         errors++; $display("FAIL data_count: got %0d want 4", valid_cnt);
      end
      checks++;
      if (first_valid_off != 192 || gap_bad != 0) begin
         errors++; $display("FAIL data_timing: got first %0d gaps_bad %0d want 192/0", first_valid_off, gap_bad);
      end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL data_byte: got %h want %h", got, want);
         end
      end
      repeat (5) @(negedge sys_clk);
      checks++;
      if (rd_data0 !== 8'h00 || rd_valid_v[0] !== 1'b0) begin
         errors++; $display("FAIL data_hold: got %h/%b want 00/0", rd_data0, rd_valid_v[0]);
      end
   endtask

   task automatic test_ignored_start();
      logic [7:0] got, want;
      int         bad;
      sel = 1;
      exp_q.delete();
      for (int i = 0; i < 270; i++) exp_q.push_back(mem[10'(24'h0000C8 + 24'(i))]);
      run_txn(1, 3 * 32 + 5, 6 * 32 + 5);
      checks++;
      if (valid_cnt != 270 || done_cnt != 1) begin
         errors++; $display("FAIL ignore_counts: got %0d valid/%0d done want 270/1", valid_cnt, done_cnt);
      end
      checks++;
      if (cs_low_cnt != 8832 || cs_fall_cnt != 1) begin
         errors++; $display("FAIL ignore_cs_low: got %0d cycles/%0d falls want 8832/1", cs_low_cnt, cs_fall_cnt);
      end
      checks++;
      if (last_rises != 32 + 8 * 270 || mosi_bad != 0 || busy_bad != 0) begin
         errors++; $display("FAIL ignore_pins: got %0d rises/%0d mosi/%0d busy want 2192/0/0",
                            last_rises, mosi_bad, busy_bad);
      end
      bad = 0;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         checks++;
         if (got !== want) begin
            errors++; bad++;
            if (bad < 8) $display("FAIL ignore_byte: got %h want %h", got, want);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      int         nv, dn;
      logic [7:0] got, want;
      sel = 1;
      nv = 0;
      @(negedge sys_clk);
      key_flag[1] = 1'b1;
      @(negedge sys_clk);
      key_flag[1] = 1'b0;
      for (int c = 0; c < 2000 && nv < 10; c++) begin
         @(negedge sys_clk);
         if (rd_valid_v[1] === 1'b1) nv++;
      end
      checks++;
      if (nv != 10) begin
         errors++; $display("FAIL abort_reach: got %0d bytes want 10", nv);
      end
      repeat (9) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      checks++;
      if ({spi1.cs_n, spi1.sck, rd_valid_v[1], busy_v[1]} !== 4'b1000) begin
         errors++; $display("FAIL abort_outputs: got %b want 1000",
                            {spi1.cs_n, spi1.sck, rd_valid_v[1], busy_v[1]});
      end
      sys_rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge sys_clk);
         if (done_v[1] === 1'b1 || spi1.cs_n !== 1'b1) dn++;
      end
      checks++;
      if (dn != 0) begin
         errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dn);
      end
      exp_q.delete();
      for (int i = 0; i < 270; i++) exp_q.push_back(mem[10'(24'h0000C8 + 24'(i))]);
      run_txn(1, -1, -1);
      checks++;
      if (valid_cnt != 270 || done_cnt != 1 || cs_low_cnt != 8832) begin
         errors++; $display("FAIL abort_reread: got %0d valid/%0d done/%0d low want 270/1/8832",
                            valid_cnt, done_cnt, cs_low_cnt);
      end
      nv = 0;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         if (got !== want) nv++;
      end
      checks++;
      if (nv != 0) begin
         errors++; $display("FAIL abort_reread_bytes: got %0d wrong bytes want 0", nv);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, want;
      sel = 2;
      for (int r = 0; r < 2; r++) begin
         exp_q.delete();
         exp_q.push_back(mem[10'h0C8]);
         run_txn(2, -1, -1);
         checks++;
         if (valid_cnt != 1 || done_cnt != 1 || first_valid_off != 192) begin
            errors++; $display("FAIL b2b_valid run%0d: got %0d valid/%0d done/first %0d want 1/1/192",
                               r, valid_cnt, done_cnt, first_valid_off);
         end
         checks++;
         if (cs_low_cnt != 224 || cs_fall_cnt != 1) begin
            errors++; $display("FAIL b2b_cs_low run%0d: got %0d/%0d want 224/1", r, cs_low_cnt, cs_fall_cnt);
         end
         checks++;
         if (rx_sr !== 32'h030000C8 || last_rises != 40) begin
            errors++; $display("FAIL b2b_cmd run%0d: got %h/%0d rises want 030000c8/40", r, rx_sr, last_rises);
         end
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL b2b_byte run%0d: got %h want %h", r, got, want);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[10'h0C8] = 8'hA5;
      mem[10'h0C9] = 8'h3C;
      mem[10'h0CA] = 8'hFF;
      mem[10'h0CB] = 8'h00;
      test_reset();
      repeat (2) @(negedge sys_clk);
      test_cmd_addr();
      test_read_data();
      test_ignored_start();
      test_reset_mid_read();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
